janela_amostras: RTL

- Sample-window builder directly upstream of `filtrodown`.
- Accepts a serial stream of unsigned pixels, one line at a time, and presents 7 consecutive samples as `in0`..`in6`, centred on each pixel.
- Pixels past either line edge are replaced by the nearest edge pixel.
- Produces exactly one window per input pixel; `out_valid` drives the filter's `enable`.

---
 rtl/janela_amostras.sv | 120 ++++++++++++
 1 files changed

// File: rtl/janela_amostras.sv
// janela_amostras: builds a 7-tap sliding window over a line of unsigned pixels.
// Pixels beyond either line edge repeat the nearest edge pixel. One window is
// produced per input pixel, with in3 holding the centre pixel.
module janela_amostras #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic        [DATA_WIDTH-1:0] in_data,
  input  logic                         line_last,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH+1:0] in0,
  output logic signed [DATA_WIDTH+1:0] in1,
  output logic signed [DATA_WIDTH+1:0] in2,
  output logic signed [DATA_WIDTH+1:0] in3,
  output logic signed [DATA_WIDTH+1:0] in4,
  output logic signed [DATA_WIDTH+1:0] in5,
  output logic signed [DATA_WIDTH+1:0] in6
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q [7];
  logic [DATA_WIDTH-1:0] sr_d [7];
  logic [1:0]            shcnt_q, shcnt_d;
  logic [1:0]            flcnt_q, flcnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  accept;
  logic                  shift;

  assign in_ready = enable & (state_q != FLUSH);
  assign accept   = in_valid & in_ready;

  // The taps are the shift register itself, zero-extended so the sign bit stays clear.
  assign in0 = {2'b00, sr_q[0]};
  assign in1 = {2'b00, sr_q[1]};
  assign in2 = {2'b00, sr_q[2]};
  assign in3 = {2'b00, sr_q[3]};
  assign in4 = {2'b00, sr_q[4]};
  assign in5 = {2'b00, sr_q[5]};
  assign in6 = {2'b00, sr_q[6]};
  assign out_valid = out_valid_q;

  // Next-state logic: load on first pixel, shift on later pixels, replicate last pixel while flushing.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    shcnt_d     = shcnt_q;
    flcnt_d     = flcnt_q;
    shift       = 1'b0;
    out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          for (int unsigned i = 0; i < 7; i++) sr_d[i] = in_data;
          shcnt_d = '0;
          flcnt_d = '0;
          state_d = line_last ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          for (int unsigned i = 0; i < 6; i++) sr_d[i] = sr_q[i+1];
          sr_d[6] = in_data;
          shift   = 1'b1;
          if (line_last) begin
            flcnt_d = '0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (enable) begin
          for (int unsigned i = 0; i < 6; i++) sr_d[i] = sr_q[i+1];
          sr_d[6] = sr_q[6];
          shift   = 1'b1;
          if (flcnt_q == 2'd2) begin
            flcnt_d = '0;
            state_d = IDLE;
          end else begin
            flcnt_d = flcnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (shift) begin
      shcnt_d     = (shcnt_q == 2'd3) ? 2'd3 : shcnt_q + 2'd1;
      out_valid_d = (shcnt_d == 2'd3);
    end
  end

  // State, window and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      shcnt_q     <= '0;
      flcnt_q     <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < 7; i++) sr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      shcnt_q     <= shcnt_d;
      flcnt_q     <= flcnt_d;
      out_valid_q <= out_valid_d;
      sr_q        <= sr_d;
    end
  end

endmodule
